rob_ctrl: RTL and testbench
===========================

// Module: rob_ctrl
// PURPOSE
// Sequencing controller for the reorder buffer built from DEPTH per-slot ROB entries.
// Owns the head/tail pointers and the occupancy count. Steers one-hot enqueue strobes from
// rename/dispatch into free slots. Retires up to two completed entries per cycle in program
// order and broadcasts flush. Sits between dispatch and the entry array; commit outputs feed
// the rename free-list and the arch RAT.
// PARAMETERS
// DEPTH   32   number of ROB entries; power of two, >=4
// IDX_W   $clog2(DEPTH)   entry index width (derived, do not override)
// PORTS
// clock            in   1          core clock
// reset_n          in   1          async active-low reset
// enq_valid        in   1          dispatch has one instruction to allocate
// enq_ready        out  1          controller accepts allocation this cycle
// enq_robidx       out  IDX_W+1    {wrap,idx} assigned to the instruction (= tail)
// entry_enq        out  DEPTH      one-hot enqueue strobe to entry[tail]
// entry_valid      in   DEPTH      per-entry valid
// entry_deq        in   DEPTH      per-entry valid&complete (ready to retire)
// entry_commit     out  DEPTH      commit strobe(s) to retiring entries (<=2 bits set)
// flush            in   1          redirect/exception flush request
// entry_flush      out  1          flush broadcast to all entries
// commit_valid     out  2          slot0/slot1 retire this cycle (slot1 implies slot0)
// commit_robidx0   out  IDX_W      index retired in slot0 (= head)
// commit_robidx1   out  IDX_W      index retired in slot1 (= head+1 mod DEPTH)
// rob_count        out  IDX_W+1    occupancy, 0..DEPTH
// rob_empty        out  1          rob_count==0
// BEHAVIOUR
// - Reset: head=tail=0 (wrap bits 0), count=0, state=RUN. All outputs 0 except enq_ready=1
//   and rob_empty=1.
// - Pointers are IDX_W+1 bits, with the MSB as the wrap bit. Index = ptr[IDX_W-1:0]; increments
//   wrap DEPTH-1 -> 0 and toggle the MSB.
// - enq_ready = (state==RUN) & (count<DEPTH) & ~flush. It never depends on same-cycle commit.
// - enq fire = enq_valid & enq_ready. entry_enq[tail]=1 only on fire (combinational, same
//   cycle). tail increments at the clock edge.
// - Commit is combinational from registered state; it is gated by (state==RUN) & ~flush.
//   - slot0 = count>=1 & entry_deq[head].
//   - slot1 = slot0 & count>=2 & entry_deq[head+1].
//   - No slot1 without slot0: in-order retire.
//   - entry_commit bits are set for the retiring indices. head advances by commit_num (0/1/2).
// - Next count = count + enq_fire - commit_num. Simultaneous enq and commit at full: enq is
//   refused (count==DEPTH); commit proceeds.
// - Consistency: count == tail-head (IDX_W+1-bit subtraction). full when idx equal & wrap
//   differ; empty when equal.
// - FSM:
//   - RUN: flush=1 -> FLUSH.
//   - FLUSH: one cycle; enq_ready=0, no commit; then -> RUN. A flush during FLUSH stays in
//     FLUSH.
// - Flush:
//   - entry_flush = flush, combinational, so entries clear on the same edge.
//   - Same edge: head=tail=0, count=0.
//   - Any enq or commit requested in the flush cycle is dropped.
// - Reset mid-operation: async clear to reset values regardless of state.
// - entry_valid is used only for an assertion: entry_valid[i] must equal "i lies in
//   [head,tail)". It has no functional effect.
// TESTING
// - Reset, then 5 enqs with no writeback -> enq_robidx 0..4, count=5, commit_valid=00,
//   entry_enq one-hot each cycle.
// - Entries 0,1 complete in the same cycle -> commit_valid=11, robidx0=0, robidx1=1,
//   entry_commit=0x3, head=2, count=3.
// - Entry 1 complete, entry 0 not -> commit_valid=00. Then entry 0 completes -> both retire
//   together.
// - Fill DEPTH=32 -> enq_ready=0 at count=32. The cycle head retires with enq_valid=1 ->
//   enq refused, count=31; next cycle enq accepted at idx 0, wrap=1.
// - Wrap: 40 enq/commit pairs at steady state -> robidx MSB toggles after idx 31; count
//   stays constant.
// - flush with enq_valid=1 and head complete -> no enq, no commit, entry_flush=1; next cycle
//   count=0, head=tail=0, enq_ready=0; the cycle after, enq_ready=1.

Source files
------------

// File: rtl/rob_ctrl.sv
// Reorder-buffer sequencing controller: head/tail/occupancy tracking, one-hot enqueue
// steering, in-order dual retire and flush broadcast for DEPTH per-slot ROB entries.
module rob_ctrl #(
    parameter  int DEPTH = 32,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enq_valid,
    output logic             enq_ready,
    output logic [IDX_W:0]   enq_robidx,
    output logic [DEPTH-1:0] entry_enq,
    input  logic [DEPTH-1:0] entry_valid,
    input  logic [DEPTH-1:0] entry_deq,
    output logic [DEPTH-1:0] entry_commit,
    input  logic             flush,
    output logic             entry_flush,
    output logic [1:0]       commit_valid,
    output logic [IDX_W-1:0] commit_robidx0,
    output logic [IDX_W-1:0] commit_robidx1,
    output logic [IDX_W:0]   rob_count,
    output logic             rob_empty
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

    state_t           state_q, state_d;
    logic [IDX_W:0]   head_q, head_d;
    logic [IDX_W:0]   tail_q, tail_d;
    logic [IDX_W:0]   count_q, count_d;

    logic [IDX_W-1:0] head_idx, head_nxt_idx, tail_idx;
    logic             run, enq_fire, slot0, slot1;
    logic [1:0]       commit_num;
    logic [DEPTH-1:0] occ_mask;

    assign head_idx     = head_q[IDX_W-1:0];
    assign head_nxt_idx = head_idx + 1'b1;
    assign tail_idx     = tail_q[IDX_W-1:0];

    always_comb begin
        run       = (state_q == ST_RUN);
        enq_ready = run & (count_q < DEPTH_C) & ~flush;
        enq_fire  = enq_valid & enq_ready;

        entry_enq = '0;
        if (enq_fire) begin
            entry_enq[tail_idx] = 1'b1;
        end

        // Retire strictly in order: slot1 can only go when slot0 goes.
        slot0 = run & ~flush & (count_q >= (IDX_W+1)'(1)) & entry_deq[head_idx];
        slot1 = slot0 & (count_q >= (IDX_W+1)'(2)) & entry_deq[head_nxt_idx];

        entry_commit = '0;
        if (slot0) begin
            entry_commit[head_idx] = 1'b1;
        end
        if (slot1) begin
            entry_commit[head_nxt_idx] = 1'b1;
        end

        commit_num     = {1'b0, slot0} + {1'b0, slot1};
        commit_valid   = {slot1, slot0};
        commit_robidx0 = slot0 ? head_idx : '0;
        commit_robidx1 = slot1 ? head_nxt_idx : '0;

        enq_robidx  = tail_q;
        entry_flush = flush;
        rob_count   = count_q;
        rob_empty   = (count_q == '0);
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            state_d = ST_FLUSH;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (state_q == ST_FLUSH) begin
            state_d = ST_RUN;
        end else begin
            tail_d  = tail_q + (IDX_W+1)'(enq_fire);
            head_d  = head_q + (IDX_W+1)'(commit_num);
            count_d = count_q + (IDX_W+1)'(enq_fire) - (IDX_W+1)'(commit_num);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Slot i is live when its distance past head is below the occupancy; covers the full case.
    always_comb begin
        occ_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_mask[i] = {1'b0, IDX_W'(i) - head_idx} < count_q;
        end
    end

    a_entry_valid: assert property (@(posedge clock) disable iff (!reset_n)
        entry_valid == occ_mask);
    a_count_ptr: assert property (@(posedge clock) disable iff (!reset_n)
        count_q == (tail_q - head_q));

endmodule

// File: tb/tb_rob_ctrl.sv
// Scoreboard bench for rob_ctrl: a cycle model pushes expected outputs per stimulus
// cycle and each is popped and compared against the DUT in the same cycle.
module tb_rob_ctrl;

    localparam int DEPTH = 32;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    logic [5:0]  enq_robidx;
    logic [31:0] entry_enq;
    logic [31:0] entry_valid = '0;
    logic [31:0] entry_deq = '0;
    logic [31:0] entry_commit;
    logic        flush = 1'b0;
    logic        entry_flush;
    logic [1:0]  commit_valid;
    logic [4:0]  commit_robidx0;
    logic [4:0]  commit_robidx1;
    logic [5:0]  rob_count;
    logic        rob_empty;

    rob_ctrl #(.DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .enq_valid      (enq_valid),
        .enq_ready      (enq_ready),
        .enq_robidx     (enq_robidx),
        .entry_enq      (entry_enq),
        .entry_valid    (entry_valid),
        .entry_deq      (entry_deq),
        .entry_commit   (entry_commit),
        .flush          (flush),
        .entry_flush    (entry_flush),
        .commit_valid   (commit_valid),
        .commit_robidx0 (commit_robidx0),
        .commit_robidx1 (commit_robidx1),
        .rob_count      (rob_count),
        .rob_empty      (rob_empty)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rdy;
        logic [5:0]  robidx;
        logic [31:0] enq;
        logic [31:0] commit;
        logic [1:0]  cv;
        logic [4:0]  i0;
        logic [4:0]  i1;
        logic        fl;
        logic [5:0]  cnt;
        logic        empty;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_head = 0;
    int m_tail = 0;
    int m_count = 0;
    int m_flushst = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] occ(input int h, input int c);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = (((i - (h % DEPTH)) + DEPTH) % DEPTH) < c;
        end
        return m;
    endfunction

    task automatic model_reset();
        m_head = 0;
        m_tail = 0;
        m_count = 0;
        m_flushst = 0;
    endtask

    task automatic step(input logic ev, input logic [31:0] deq, input logic fl);
        exp_t e, g;
        int   hi, hn, ti;
        logic run, rdy, fire, s0, s1;
        @(negedge clock);
        enq_valid   = ev;
        entry_deq   = deq;
        flush       = fl;
        entry_valid = occ(m_head, m_count);

        hi   = m_head % DEPTH;
        hn   = (hi + 1) % DEPTH;
        ti   = m_tail % DEPTH;
        run  = (m_flushst == 0);
        rdy  = run && (m_count < DEPTH) && !fl;
        fire = ev && rdy;
        s0   = run && !fl && (m_count >= 1) && deq[hi];
        s1   = s0 && (m_count >= 2) && deq[hn];

        e.rdy    = rdy;
        e.robidx = 6'(m_tail);
        e.enq    = fire ? (32'h1 << ti) : 32'h0;
        e.commit = (s0 ? (32'h1 << hi) : 32'h0) | (s1 ? (32'h1 << hn) : 32'h0);
        e.cv     = {s1, s0};
        e.i0     = s0 ? 5'(hi) : 5'd0;
        e.i1     = s1 ? 5'(hn) : 5'd0;
        e.fl     = fl;
        e.cnt    = 6'(m_count);
        e.empty  = (m_count == 0);
        sb.push_back(e);

        if (fl) begin
            model_reset();
            m_flushst = 1;
        end else if (m_flushst != 0) begin
            m_flushst = 0;
        end else begin
            m_tail  = (m_tail + int'(fire)) % (2 * DEPTH);
            m_head  = (m_head + int'(s0) + int'(s1)) % (2 * DEPTH);
            m_count = m_count + int'(fire) - int'(s0) - int'(s1);
        end

        #1;
        g = sb.pop_front();
        chk("enq_ready",    64'(enq_ready),      64'(g.rdy));
        chk("enq_robidx",   64'(enq_robidx),     64'(g.robidx));
        chk("entry_enq",    64'(entry_enq),      64'(g.enq));
        chk("entry_commit", 64'(entry_commit),   64'(g.commit));
        chk("commit_valid", 64'(commit_valid),   64'(g.cv));
        chk("robidx0",      64'(commit_robidx0), 64'(g.i0));
        chk("robidx1",      64'(commit_robidx1), 64'(g.i1));
        chk("entry_flush",  64'(entry_flush),    64'(g.fl));
        chk("rob_count",    64'(rob_count),      64'(g.cnt));
        chk("rob_empty",    64'(rob_empty),      64'(g.empty));
    endtask

    function automatic logic [31:0] head_bit();
        return 32'h1 << (m_head % DEPTH);
    endfunction

    initial begin
        model_reset();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // Reset state
        step(1'b0, '0, 1'b0);
        chk("rst_ready", 64'(enq_ready), 64'd1);
        chk("rst_empty", 64'(rob_empty), 64'd1);

        // Five allocations, nothing written back
        for (int i = 0; i < 5; i++) begin
            step(1'b1, '0, 1'b0);
            chk("alloc_idx", 64'(enq_robidx), 64'(i));
        end

        // Entries 0 and 1 retire together
        step(1'b0, 32'h3, 1'b0);
        chk("dual_cv", 64'(commit_valid), 64'd3);
        chk("dual_commit", 64'(entry_commit), 64'h3);
        step(1'b0, '0, 1'b0);
        chk("dual_cnt", 64'(rob_count), 64'd3);

        // Younger complete, older not: nothing retires; then both go
        step(1'b0, 32'h8, 1'b0);
        chk("ooo_block", 64'(commit_valid), 64'd0);
        step(1'b0, 32'hC, 1'b0);
        chk("ooo_pair", 64'(commit_valid), 64'd3);

        // Flush with a pending enqueue and a completed head
        step(1'b1, head_bit(), 1'b1);
        chk("flush_bcast", 64'(entry_flush), 64'd1);
        step(1'b1, '0, 1'b0);
        chk("flush_hold", 64'(enq_ready), 64'd0);
        step(1'b0, '0, 1'b0);
        chk("flush_resume", 64'(enq_ready), 64'd1);

        // Fill to DEPTH, then commit and enqueue in the same cycle at full
        for (int i = 0; i < DEPTH; i++) step(1'b1, '0, 1'b0);
        step(1'b1, '0, 1'b0);
        chk("full_ready", 64'(enq_ready), 64'd0);
        step(1'b1, head_bit(), 1'b0);
        chk("full_refuse", 64'(entry_enq), 64'd0);
        step(1'b1, '0, 1'b0);
        chk("wrap_idx", 64'(enq_robidx), 64'd32);

        // Steady-state enq/commit pairs across the wrap point
        step(1'b0, head_bit(), 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, head_bit(), 1'b0);
        chk("steady_cnt", 64'(rob_count), 64'd31);

        // Random traffic with an asynchronous reset in the middle
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                @(negedge clock);
                #2;
                reset_n     = 1'b0;
                enq_valid   = 1'b0;
                entry_deq   = '0;
                flush       = 1'b0;
                entry_valid = '0;
                #1;
                model_reset();
                chk("async_rst_cnt", 64'(rob_count), 64'd0);
                chk("async_rst_ready", 64'(enq_ready), 64'd1);
                @(negedge clock);
                reset_n = 1'b1;
            end
            step(1'($urandom_range(0, 3) != 0), $urandom(), 1'($urandom_range(0, 39) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
